// File: rtl/dpram_be.sv
// dpram_be: single-clock true dual-port RAM with per-byte write enables,
// registered read outputs and a clear engine that fills every word with
// clear_byte after each reset.
// Optional feature macro: DPRAM_BYPASS_EN. When it is defined, a port that
// reads the address the other port writes on the same edge gets the new
// (merged) word. Otherwise it gets the old word.
module dpram_be #(
  parameter int unsigned addr_width = 8,
  parameter int unsigned data_width = 8,
  parameter logic [7:0]  clear_byte = 8'h00
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    busy,
  input  logic                    a_cs,
  input  logic                    a_wren,
  input  logic [data_width/8-1:0] a_be,
  input  logic [addr_width-1:0]   a_address,
  input  logic [data_width-1:0]   a_data,
  output logic [data_width-1:0]   a_q,
  input  logic                    b_cs,
  input  logic                    b_wren,
  input  logic [data_width/8-1:0] b_be,
  input  logic [addr_width-1:0]   b_address,
  input  logic [data_width-1:0]   b_data,
  output logic [data_width-1:0]   b_q
);

  localparam int unsigned           lanes = data_width / 8;
  localparam int unsigned           depth = 1 << addr_width;
  localparam logic [data_width-1:0] ones  = {data_width{1'b1}};
  localparam logic [data_width-1:0] fill  = {lanes{clear_byte}};

  logic [data_width-1:0] mem_q [depth];
  logic [addr_width-1:0] clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic [data_width-1:0] a_q_q, a_q_d, b_q_q, b_q_d;

  logic                  a_rd, b_rd, a_wr, b_wr, clr_we, same_addr;
  logic [data_width-1:0] a_old, b_old, a_new, b_new;

  // Ports are ignored while the clear sweep runs; a write needs a lane set.
  assign a_rd      = a_cs && !busy_q;
  assign b_rd      = b_cs && !busy_q;
  assign a_wr      = a_rd && a_wren && (|a_be);
  assign b_wr      = b_rd && b_wren && (|b_be);
  assign clr_we    = reset_n && busy_q;
  assign same_addr = (a_address == b_address);
  assign busy      = busy_q;
  assign a_q       = a_q_q;
  assign b_q       = b_q_q;

  // Post-edge word at each port's address, with port A winning per lane.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    a_old = mem_q[a_address];
    b_old = mem_q[b_address];
    a_new = a_old;
    b_new = b_old;
    for (int i = 0; i < int'(lanes); i++) begin
      if (a_wr && a_be[i])
        a_new[8*i +: 8] = a_data[8*i +: 8];
      else if (b_wr && b_be[i] && same_addr)
        a_new[8*i +: 8] = b_data[8*i +: 8];

      if (a_wr && a_be[i] && same_addr)
        b_new[8*i +: 8] = a_data[8*i +: 8];
      else if (b_wr && b_be[i])
        b_new[8*i +: 8] = b_data[8*i +: 8];
    end
  end

  // Read data selection: all ones when deselected or busy, else old word
  // (or forwarded new word for a cross-port write in the bypass build).
  always_comb begin
    a_q_d = ones;
    b_q_d = ones;
`ifdef DPRAM_BYPASS_EN
    if (a_rd) a_q_d = (b_wr && same_addr) ? a_new : a_old;
    if (b_rd) b_q_d = (a_wr && same_addr) ? b_new : b_old;
`else
    if (a_rd) a_q_d = a_old;
    if (b_rd) b_q_d = b_old;
`endif
  end

  // Clear-engine next state: step through every address once, then idle.
  always_comb begin
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    if (busy_q) begin
      clr_cnt_d = clr_cnt_q + addr_width'(1);
      if (clr_cnt_q == {addr_width{1'b1}}) busy_d = 1'b0;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      a_q_q     <= ones;
      b_q_q     <= ones;
    end else begin
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      a_q_q     <= a_q_d;
      b_q_q     <= b_q_d;
    end
  end

  // Array writes: clear sweep, else merged user words (A's word already
  // includes B's lanes on a collision, so B skips that address).
  always_ff @(posedge clock) begin
    // NOTE: the array itself has no reset branch; the clear engine provides
    // its known contents, which keeps the array mappable onto block RAM.
    if (clr_we) begin
      mem_q[clr_cnt_q] <= fill;
    end else begin
      if (a_wr) mem_q[a_address] <= a_new;
      if (b_wr && !(a_wr && same_addr)) mem_q[b_address] <= b_new;
    end
  end

endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: self-checking bench for dpram_be (addr_width=4, data_width=32,
// clear_byte=8'hA5). A behavioural model predicts busy, a_q and b_q for every
// clock edge; directed sequences cover the clear sweep, byte enables,
// collisions, read-during-write and gating, followed by a random phase.
module tb_dpram_be;

  localparam int          AW    = 4;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] ONES  = 32'hFFFF_FFFF;
  localparam logic [31:0] FILL  = 32'hA5A5_A5A5;
`ifdef DPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          busy;
  logic          a_cs, a_wren, b_cs, b_wren;
  logic [3:0]    a_be, b_be;
  logic [AW-1:0] a_address, b_address;
  logic [DW-1:0] a_data, b_data, a_q, b_q;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  bit          m_busy;
  int          m_cnt;

  always #5 clock = ~clock;

  dpram_be #(.addr_width(AW), .data_width(DW), .clear_byte(8'hA5)) dut (
    .clock(clock), .reset_n(reset_n), .busy(busy),
    .a_cs(a_cs), .a_wren(a_wren), .a_be(a_be), .a_address(a_address),
    .a_data(a_data), .a_q(a_q),
    .b_cs(b_cs), .b_wren(b_wren), .b_be(b_be), .b_address(b_address),
    .b_data(b_data), .b_q(b_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_cs = 0; a_wren = 0; a_be = 0; a_address = 0; a_data = 0;
    b_cs = 0; b_wren = 0; b_be = 0; b_address = 0; b_data = 0;
  endtask

  // Predict the effect of the coming edge, apply it, then compare.
  task automatic do_edge();
    logic [31:0] old_m [DEPTH];
    logic [31:0] new_m [DEPTH];
    logic [31:0] ea, eb;
    bit          aw, bw;
    ea = ONES;
    eb = ONES;
    if (!reset_n) begin
      m_busy = 1;
      m_cnt  = 0;
    end else if (m_busy) begin
      ref_mem[m_cnt] = FILL;
      m_cnt++;
      if (m_cnt == DEPTH) m_busy = 0;
    end else begin
      old_m = ref_mem;
      new_m = ref_mem;
      aw = a_cs && a_wren && (a_be != 0);
      bw = b_cs && b_wren && (b_be != 0);
      // Apply B first, then A, so A owns any lane both enable.
      for (int l = 0; l < 4; l++)
        if (bw && b_be[l]) new_m[b_address][8*l +: 8] = b_data[8*l +: 8];
      for (int l = 0; l < 4; l++)
        if (aw && a_be[l]) new_m[a_address][8*l +: 8] = a_data[8*l +: 8];
      if (a_cs) ea = (BYP && bw && b_address == a_address) ? new_m[a_address] : old_m[a_address];
      if (b_cs) eb = (BYP && aw && a_address == b_address) ? new_m[b_address] : old_m[b_address];
      ref_mem = new_m;
    end
    @(posedge clock);
    #1;
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("a_q", a_q, ea);
    check("b_q", b_q, eb);
  endtask

  // Edges until busy drops, bounded; returns the count.
  task automatic sweep(output int n);
    n = 0;
    do begin
      do_edge();
      n++;
    end while (busy && n < 40);
  endtask

  task automatic wr_a(input logic [AW-1:0] ad, input logic [31:0] d, input logic [3:0] be);
    a_cs = 1; a_wren = 1; a_address = ad; a_data = d; a_be = be;
  endtask

  task automatic rd_a(input logic [AW-1:0] ad);
    a_cs = 1; a_wren = 0; a_address = ad; a_be = 0;
  endtask

  initial begin
    int n;
    m_busy  = 1;
    m_cnt   = 0;
    reset_n = 0;
    idle();
    // Reset state.
    do_edge();
    do_edge();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_a_q", a_q, ONES);

    // First sweep, with an access issued during it that must be lost.
    reset_n = 1;
    wr_a(4'd2, 32'h1234_5678, 4'hF);
    b_cs = 1; b_address = 4'd2;
    sweep(n);
    check("clear_len", n, 32'd16);
    idle();

    // Every address reads the fill value on both ports.
    for (int i = 0; i < DEPTH; i++) begin
      rd_a(AW'(i));
      b_cs = 1; b_address = AW'(DEPTH - 1 - i);
      do_edge();
      check("fill_a", a_q, FILL);
    end
    idle();

    // Reset pulse at sweep edge 7 restarts the sweep.
    reset_n = 0; do_edge();
    reset_n = 1;
    for (int i = 0; i < 7; i++) do_edge();
    reset_n = 0; do_edge();
    reset_n = 1;
    sweep(n);
    check("restart_len", n, 32'd16);

    // Byte enables.
    wr_a(4'd5, 32'h1122_3344, 4'b1111); do_edge();
    wr_a(4'd5, 32'hAABB_CCDD, 4'b0101); do_edge();
    rd_a(4'd5); do_edge();
    check("be_merge", a_q, 32'h11BB_33DD);

    // Write collision.
    wr_a(4'd6, 32'h0000_00FF, 4'b0001);
    b_cs = 1; b_wren = 1; b_address = 4'd6; b_data = 32'hEEEE_EEEE; b_be = 4'b1111;
    do_edge();
    idle();
    rd_a(4'd6); do_edge();
    check("collision", a_q, 32'hEEEE_EEFF);

    // Read-during-write.
    wr_a(4'd3, 32'h10, 4'hF); do_edge();
    wr_a(4'd3, 32'h20, 4'hF);
    b_cs = 1; b_wren = 0; b_address = 4'd3;
    do_edge();
    check("rdw_b", b_q, BYP ? 32'h20 : 32'h10);
    check("rdw_a", a_q, 32'h10);
    idle();

    // Deselected port neither writes nor reads.
    rd_a(4'd7); do_edge();
    a_cs = 0; a_wren = 1; a_be = 4'hF; a_data = 32'hDEAD_BEEF;
    do_edge();
    check("cs0_q", a_q, ONES);
    rd_a(4'd7); do_edge();
    check("cs0_mem", a_q, FILL);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      a_cs      = $urandom_range(0, 3) != 0;
      a_wren    = $urandom_range(0, 1);
      a_be      = 4'($urandom);
      a_address = AW'($urandom_range(0, 5));
      a_data    = $urandom;
      b_cs      = $urandom_range(0, 3) != 0;
      b_wren    = $urandom_range(0, 1);
      b_be      = 4'($urandom);
      b_address = AW'($urandom_range(0, 5));
      b_data    = $urandom;
      do_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_be.md
# dpram_be

Single-clock, true dual-port RAM with per-byte write enables, registered read outputs and a built-in clear engine. After every reset it fills the whole array with a fixed byte value. It is the general-purpose successor to the simple single-port simulation RAM. It backs video line buffers, CPU work RAM and shared mailboxes in the sim and core top levels, wherever two masters need independent ports or partial-word writes.

## Interface
- addr_width, 8: address bits per port; depth = 2**addr_width words
- data_width, 8: word width; must be a multiple of 8
- clear_byte, 8'h00: byte written to every lane of every word by the clear engine

- clock  in  1  single clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- busy  out  1  high while reset is asserted and while the clear sweep runs
- a_cs  in  1  port A select
- a_wren  in  1  port A write request
- a_be  in  data_width/8  port A byte-lane write enables; lane i = bits [8i+7:8i]
- a_address  in  addr_width  port A word address
- a_data  in  data_width  port A write data
- a_q  out  data_width  port A registered read data
- b_cs, b_wren, b_be, b_address, b_data, b_q: identical to port A, for port B

## Operation
- Clear engine:
  - While reset_n=0: clear counter=0, busy=1, a_q=b_q=all ones.
  - Each edge with reset_n=1 and busy=1: writes clear_byte to all lanes of mem[counter], then counter increments.
  - The edge that writes address 2**addr_width-1 also sets busy=0.
  - Asserting reset_n=0 mid-sweep restarts the sweep from address 0.
- While busy=1, both ports are ignored. No user writes are performed, and a_q/b_q register all ones.
- Write (busy=0, x_cs=1, x_wren=1): lanes with x_be[i]=1 take x_data lane i. Other lanes are unchanged. x_be=0 performs no write.
- Read (busy=0, x_cs=1): x_q registers mem[x_address], whether x_wren is 0 or 1. Same-port read-during-write returns the OLD word (read-first).
- x_cs=0: x_q registers all ones. The port does not write regardless of x_wren and x_be.
- Write collision (both ports write the same address on the same edge):
  - Per lane, port A wins where a_be[i]=1.
  - Port B writes lanes where b_be[i]=1 and a_be[i]=0.
- Cross-port read-during-write (one port reads an address the other port writes on the same edge): behaviour is set by DPRAM_BYPASS_EN.

## Timing
- Read latency: 1 cycle. x_q after edge k reflects the address and cs sampled at edge k.
- x_q holds its value between accesses only while cs stays high and the address is unchanged. It re-registers on every edge.
- Write takes effect at the sampling edge and is visible to a read sampled at the next edge.
- Clear duration: busy falls at the 2**addr_width-th edge after reset_n rises. Default is 256 cycles.
- Reset values: busy=1, a_q=all ones, b_q=all ones, clear counter=0.

## Configuration
- DPRAM_BYPASS_EN defined: cross-port read-during-write returns the NEW word. The reader gets the post-write merged value, including collision resolution, on the same latency.
- DPRAM_BYPASS_EN undefined: the reader gets the OLD word. This is plain dual-port array behaviour with no forwarding mux.
- Same-port behaviour is read-first in both builds.

## Test plan
- Clear: with clear_byte=8'hA5 and addr_width=4, release reset → busy high for exactly 16 edges. Afterwards every address reads 8'hA5 on both ports. Pulsing reset_n low at sweep edge 7 restarts the sweep, and busy stays high for 16 more edges.
- Byte enables: with data_width=32, write 32'h11223344 with be=4'b1111, then 32'hAABBCCDD with be=4'b0101 → read returns 32'h11BB33DD.
- Collision: same address, A writes 32'h000000FF with be=4'b0001 and B writes 32'hEEEEEEEE with be=4'b1111 → word reads 32'hEEEEEEFF.
- Read-during-write: mem[3]=8'h10, A writes 8'h20 to 3 while B reads 3. Without the macro b_q=8'h10; with DPRAM_BYPASS_EN b_q=8'h20. A reading its own write returns 8'h10 in both builds.
- cs/busy gating: cs=0 with wren=1 → q=8'hFF and memory unchanged. An access issued during the clear sweep → q=8'hFF and the write is lost.
